lsu_mem_port: RTL and testbench

Load/store unit that acts as the initiator on the word-wide single-port data RAM (async read, sync write, no byte enables). Accepts byte/halfword/word load and store requests from the core's memory stage using byte addresses. Performs lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores. Flags misaligned accesses without touching memory.

---
 rtl/lsu_mem_port_if.sv | 42 ++++
 rtl/lsu_mem_port.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_port_if
// Description : Bundles the core-side request/response handshake and the
//               data-RAM initiator bus of the load/store unit.
//                 core side : i_req, i_we, i_size, i_signed, i_addr, i_wdata
//                             -> o_ready, o_done, o_err, o_rdata
//                 RAM side  : o_mem_addr, o_mem_data, o_mem_we -> RAM,
//                             i_mem_data <- RAM (async read)
//               slave  : the LSU's view of the bundle.
//               master : the environment's view (core + RAM).
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_port_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  i_req;
  logic                  i_we;
  logic [1:0]            i_size;
  logic                  i_signed;
  logic [31:0]           i_addr;
  logic [31:0]           i_wdata;
  logic                  o_ready;
  logic                  o_done;
  logic                  o_err;
  logic [31:0]           o_rdata;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]           o_mem_data;
  logic                  o_mem_we;
  logic [31:0]           i_mem_data;

  modport slave (
    input  i_req, i_we, i_size, i_signed, i_addr, i_wdata, i_mem_data,
    output o_ready, o_done, o_err, o_rdata, o_mem_addr, o_mem_data, o_mem_we
  );

  modport master (
    output i_req, i_we, i_size, i_signed, i_addr, i_wdata, i_mem_data,
    input  o_ready, o_done, o_err, o_rdata, o_mem_addr, o_mem_data, o_mem_we
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_port
// Description : Load/store unit driving a word-wide single-port data RAM
//               (async read, sync write, no byte enables). Byte/half/word
//               loads with sign/zero extension, sub-word stores by
//               read-modify-write, misaligned accesses flagged without
//               touching memory.
// Ports       : i_clk  - clock, all state on rising edge
//               i_rst  - asynchronous active-high reset
//               bus    - lsu_mem_port_if.slave (request handshake + RAM bus)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_err;
  logic                  r_we;
  logic                  r_signed;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_merge;
  logic [31:0]           r_rdata;

  logic                  w_misalign;
  logic                  w_word_store;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [31:0]           w_merged;
  logic                  w_unused_addr;

  // Address bits above the RAM range are ignored: accesses wrap.
  assign w_unused_addr = ^bus.i_addr[31:ADDR_WIDTH+2];

  // Size 2'b11 behaves as a word everywhere, so size[1] means "word".
  assign w_misalign = ((bus.i_size == 2'b01) & bus.i_addr[0]) |
                      (bus.i_size[1] & (|bus.i_addr[1:0]));

  assign w_word_store = r_we & r_size[1];

  // Lane extraction from the RAM word for loads.
  always_comb begin
    w_byte = bus.i_mem_data[{r_addr[1:0], 3'b000} +: 8];
    w_half = bus.i_mem_data[{r_addr[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = bus.i_mem_data;
    endcase
  end

  // Merge the store lane(s) into the word read during ACCESS.
  always_comb begin
    w_merged = r_merge;
    if (r_size == 2'b00) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_req) begin
            r_we     <= bus.i_we;
            r_size   <= bus.i_size;
            r_signed <= bus.i_signed;
            r_addr   <= bus.i_addr[ADDR_WIDTH+1:0];
            r_wdata  <= bus.i_wdata;
            r_ready  <= 1'b0;
            if (w_misalign) begin
              // Skip the RAM entirely and report straight away.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            r_rdata <= w_load;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_word_store) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_merge <= bus.i_mem_data;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Write strobe/data decode straight from state so a reset removes them
  // in the same instant the state is cleared.
  assign bus.o_mem_we   = ((r_state == S_ACCESS) & w_word_store) |
                          (r_state == S_WRITE);
  assign bus.o_mem_data = (r_state == S_WRITE)                  ? w_merged :
                          ((r_state == S_ACCESS) & w_word_store) ? r_wdata  :
                                                                   32'd0;
  assign bus.o_mem_addr = r_addr[ADDR_WIDTH+1:2];
  assign bus.o_ready    = r_ready;
  assign bus.o_done     = r_done;
  assign bus.o_err      = r_err;
  assign bus.o_rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_port
// Description : Self-checking bench for lsu_mem_port. Holds a behavioural
//               RAM, a transaction-level reference model of the LSU and a
//               per-cycle output compare, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_port;
  localparam int AW = 5;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  lsu_mem_port_if #(.ADDR_WIDTH(AW)) bus ();

  lsu_mem_port #(.ADDR_WIDTH(AW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Bench RAM driven by the DUT.
  logic [31:0] mem [2**AW];
  assign bus.i_mem_data = mem[bus.o_mem_addr];
  always @(posedge i_clk) if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] off, input logic sg);
    logic [31:0] v;
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * int'(off);
      v  = (w >> sh) & 32'hFF;
      if (sg && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      sh = 16 * int'(off[1]);
      v  = (w >> sh) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] f_store(input logic [31:0] old, input logic [1:0] sz,
                                          input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (sz[1]) return wd;
    mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    sh   = (sz == 2'b00) ? 8 * int'(off) : 16 * int'(off[1]);
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  function automatic logic f_mis(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b01) return off[0];
    if (sz[1])       return off != 2'b00;
    return 1'b0;
  endfunction

  logic [31:0] ref_mem [2**AW];
  int          m_t = 0;       // cycles since accept, 0 = idle
  int          m_L = 1;       // cycles from accept to end of done pulse
  logic        m_store = 1'b0, m_err = 1'b0, m_sg = 1'b0;
  logic [1:0]  m_sz = 2'b00, m_off = 2'b00;
  logic [31:0] m_wd = '0, m_rdata = '0;
  logic [AW-1:0] m_addr = '0;
  int          m_acc = 0;

  initial begin
    forever begin
      @(posedge i_clk or posedge i_rst);
      if (i_rst) begin
        m_t = 0; m_rdata = '0; m_addr = '0;
      end else if (m_t == 0) begin
        if (bus.i_req) begin
          m_store = bus.i_we; m_sz = bus.i_size; m_sg = bus.i_signed;
          m_wd = bus.i_wdata; m_off = bus.i_addr[1:0];
          m_addr = bus.i_addr[AW+1:2];
          m_err = f_mis(bus.i_size, bus.i_addr[1:0]);
          m_L = m_err ? 1 : ((!bus.i_we || bus.i_size[1]) ? 2 : 3);
          m_t = 1;
          m_acc++;
        end
      end else if (m_t == m_L) begin
        m_t = 0;
      end else begin
        if (m_store && m_t == m_L - 1)
          ref_mem[m_addr] = f_store(ref_mem[m_addr], m_sz, m_off, m_wd);
        m_t++;
        if (!m_store && m_t == m_L)
          m_rdata = f_load(ref_mem[m_addr], m_sz, m_off, m_sg);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int dut_dones = 0;
  initial begin
    forever begin
      @(negedge i_clk);
      begin
        logic e_busy, e_done, e_we;
        logic [31:0] e_data;
        e_busy = (m_t != 0);
        e_done = e_busy && (m_t == m_L);
        e_we   = e_busy && m_store && !m_err && (m_t == m_L - 1);
        e_data = e_we ? f_store(ref_mem[m_addr], m_sz, m_off, m_wd) : 32'd0;
        chk("cyc_ready",    32'(bus.o_ready),    32'(!e_busy));
        chk("cyc_done",     32'(bus.o_done),     32'(e_done));
        chk("cyc_err",      32'(bus.o_err),      32'(e_done && m_err));
        chk("cyc_mem_we",   32'(bus.o_mem_we),   32'(e_we));
        chk("cyc_mem_data", bus.o_mem_data,      e_data);
        chk("cyc_mem_addr", 32'(bus.o_mem_addr), 32'(m_addr));
        chk("cyc_rdata",    bus.o_rdata,         m_rdata);
        if (bus.o_done === 1'b1) dut_dones++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int          last_wec;
  logic [31:0] last_wdat;

  task automatic op(input logic we, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd,
                    input int exp_lat, input logic exp_err, output logic [31:0] rd);
    int n;
    logic seen;
    bus.i_req = 1'b1; bus.i_we = we; bus.i_size = sz; bus.i_signed = sg;
    bus.i_addr = a; bus.i_wdata = wd;
    @(posedge i_clk); #1;
    bus.i_req = 1'b0;
    n = 0; seen = 1'b0; last_wec = 0; last_wdat = '0;
    rd = '0;
    while (!seen && n < 8) begin
      @(negedge i_clk);
      n++;
      if (bus.o_mem_we === 1'b1) begin last_wec++; last_wdat = bus.o_mem_data; end
      if (bus.o_done === 1'b1) begin
        seen = 1'b1;
        chk("op_err", 32'(bus.o_err), 32'(exp_err));
        rd = bus.o_rdata;
      end
    end
    chk("op_latency", 32'(n), 32'(exp_lat));
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    int acc0, done0;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_size = 2'b00; bus.i_signed = 1'b0;
    bus.i_addr = '0; bus.i_wdata = '0;
    for (int i = 0; i < 2**AW; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    mem[0] = 32'hCAFEF00D; ref_mem[0] = 32'hCAFEF00D;
    mem[1] = 32'h11223344; ref_mem[1] = 32'h11223344;
    mem[3] = 32'h8899AABB; ref_mem[3] = 32'h8899AABB;

    #1 i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);

    op(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 2, 1'b0, rd); chk("lb_signed", rd, 32'hFFFFFFAA);
    op(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 2, 1'b0, rd); chk("lbu", rd, 32'h000000AA);
    op(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 2, 1'b0, rd); chk("lh_signed", rd, 32'hFFFF8899);
    chk("lh_no_we", 32'(last_wec), 32'd0);
    op(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 2, 1'b0, rd); chk("lw", rd, 32'h8899AABB);

    op(1'b1, 2'b01, 1'b0, 32'h0E, 32'h00001234, 3, 1'b0, rd);
    chk("sh_we_pulses", 32'(last_wec), 32'd1);
    chk("sh_we_data", last_wdat, 32'h1234AABB);
    chk("sh_ram", mem[3], 32'h1234AABB);

    op(1'b1, 2'b10, 1'b0, 32'h0D, 32'hFFFFFFFF, 1, 1'b1, rd);
    chk("mis_sw_no_we", 32'(last_wec), 32'd0);
    chk("mis_sw_ram", mem[3], 32'h1234AABB);
    op(1'b0, 2'b01, 1'b1, 32'h0F, 32'h0, 1, 1'b1, rd);
    chk("mis_lh_rdata", rd, 32'h8899AABB);

    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, rd);
    chk("sw_ram", mem[4], 32'hDEADBEEF);
    op(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 2, 1'b0, rd); chk("lbu_b3", rd, 32'h00000012);
    op(1'b0, 2'b10, 1'b0, 32'h8C, 32'h0, 2, 1'b0, rd); chk("lw_wrap", rd, 32'h1234AABB);
    op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 2, 1'b0, rd); chk("size3_word", rd, 32'hDEADBEEF);

    // Reset during ACCESS of a sub-word store: the write must never happen.
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_size = 2'b00; bus.i_addr = 32'h0;
    bus.i_wdata = 32'h55;
    @(posedge i_clk); #1;
    bus.i_req = 1'b0;
    #2 i_rst = 1'b1;
    @(negedge i_clk);
    chk("mid_rst_we", 32'(bus.o_mem_we), 32'd0);
    chk("mid_rst_ready", 32'(bus.o_ready), 32'd1);
    chk("mid_rst_rdata", bus.o_rdata, 32'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("mid_rst_ram", mem[0], 32'hCAFEF00D);
    chk("mid_rst_done", 32'(bus.o_done), 32'd0);
    chk("mid_rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);

    // Request held high, op alternating every cycle (load even, store odd).
    acc0 = m_acc; done0 = dut_dones;
    bus.i_req = 1'b1; bus.i_signed = 1'b0; bus.i_wdata = 32'h5A;
    for (int c = 0; c < 14; c++) begin
      bus.i_we   = c[0];
      bus.i_size = 2'b00;
      bus.i_addr = c[0] ? 32'h85 : 32'h84;
      @(posedge i_clk); #1;
    end
    bus.i_req = 1'b0;
    repeat (6) @(posedge i_clk);
    #1;
    chk("alt_accepts", 32'(m_acc - acc0), 32'd4);
    chk("alt_dones", 32'(dut_dones - done0), 32'd4);
    chk("alt_ram", mem[1], 32'h11225A44);
    chk("alt_rdata", bus.o_rdata, 32'h00000044);
    chk("alt_addr_wrap", 32'(bus.o_mem_addr), 32'd1);
    for (int i = 0; i < 2**AW; i++) chk("ram_vs_model", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
